// File: rtl/cgra_host_pkg.sv
// Shared definitions for the host-side CGRA job controller.
package cgra_host_pkg;

    // Job sequencing states of the host controller.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_ARM       = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RELEASE   = 3'd4,
        ST_UNLOAD    = 3'd5,
        ST_FINISH    = 3'd6
    } host_state_t;

    // Byte distance between consecutive BRAM words.
    localparam int WORD_STRIDE = 4;

    // Kernel cycle counter saturation value.
    localparam logic [31:0] KCYC_MAX = 32'hFFFF_FFFF;

    // Saturating increment for the kernel cycle counter.
    function automatic logic [31:0] kcyc_step(input logic [31:0] k);
        return (k == KCYC_MAX) ? k : k + 32'd1;
    endfunction

endpackage

// File: rtl/cgra_out_fifo.sv
// Two-entry synchronous FIFO that buffers BRAM read data toward the result
// stream. The occupancy count lets the controller throttle read issue.
module cgra_out_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign out_valid = (count != 2'd0);
    // Head entry is only overwritten after it has been popped, so the data
    // stays stable while the consumer stalls.
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign do_pop    = out_valid && out_ready;
    assign do_push   = push && ((count != 2'd2) || do_pop);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (do_push && !do_pop) begin
                count <= count + 2'd1;
            end else if (!do_push && do_pop) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule

// File: rtl/cgra_host_ctrl.sv
// Host-side job controller for the 2x2 SCGRA: loads input words into the
// shared BRAM, runs the Start/Done four-phase handshake with the array and
// streams result words back out.
//
// Cmd, In and Out streams: a word transfers on a rising clock edge where
// valid and ready are both high; a source holding valid keeps its payload
// unchanged until it is accepted, while ready may change on any cycle.
module cgra_host_ctrl
    import cgra_host_pkg::*;
#(
    parameter int SYS_DWIDTH = 32,
    parameter int BYTE_LEN   = WORD_STRIDE,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  Clk,
    input  logic                  Resetn,
    input  logic                  Cmd_Valid,
    output logic                  Cmd_Ready,
    input  logic [SYS_DWIDTH-1:0] Cmd_Load_Base,
    input  logic [SYS_DWIDTH-1:0] Cmd_Store_Base,
    input  logic [LEN_WIDTH-1:0]  Cmd_Load_Len,
    input  logic [LEN_WIDTH-1:0]  Cmd_Store_Len,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    input  logic [SYS_DWIDTH-1:0] In_Data,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic [SYS_DWIDTH-1:0] Out_Data,
    output logic                  Bram_En,
    output logic [BYTE_LEN-1:0]   Bram_Wen,
    output logic [SYS_DWIDTH-1:0] Bram_Addr,
    output logic [SYS_DWIDTH-1:0] Bram_Data_To_Bram,
    input  logic [SYS_DWIDTH-1:0] Bram_Data_From_Bram,
    output logic                  Computation_Start,
    input  logic                  Computation_Done,
    output logic                  Busy,
    output logic                  Job_Done,
    output logic [31:0]           Kernel_Cycles,
    output host_state_t           State_Dbg
);

    host_state_t           state;
    host_state_t           state_next;

    logic [SYS_DWIDTH-1:0] load_base;
    logic [SYS_DWIDTH-1:0] store_base;
    logic [LEN_WIDTH-1:0]  load_len;
    logic [LEN_WIDTH-1:0]  store_len;
    logic [LEN_WIDTH-1:0]  idx;
    logic [LEN_WIDTH-1:0]  out_cnt;
    logic                  rd_pend;
    logic                  ready_en;

    logic                  cmd_take;
    logic                  load_beat;
    logic                  start_set;
    logic                  kcyc_inc;
    logic                  rd_issue;
    logic                  out_pop;
    logic                  last_load;
    logic                  last_out;
    logic                  issue_ok;
    logic [1:0]            fifo_count;
    logic [2:0]            occ_next;
    logic [SYS_DWIDTH-1:0] idx_offset;
    logic [SYS_DWIDTH-1:0] load_addr;
    logic [SYS_DWIDTH-1:0] store_addr;

    // Word index scaled to a byte offset; wraps modulo 2^SYS_DWIDTH.
    assign idx_offset = SYS_DWIDTH'(idx) * SYS_DWIDTH'(BYTE_LEN);
    assign load_addr  = load_base + idx_offset;
    assign store_addr = store_base + idx_offset;

    assign last_load  = (idx == load_len - LEN_WIDTH'(1));
    assign last_out   = (out_cnt == store_len - LEN_WIDTH'(1));
    assign out_pop    = Out_Valid && Out_Ready;

    // Entries that will be held once this cycle settles: a pop in the same
    // cycle frees a slot, which keeps reads flowing at one word per cycle.
    assign occ_next   = {1'b0, fifo_count} + {2'b00, rd_pend} - {2'b00, out_pop};
    assign issue_ok   = (idx < store_len) && (occ_next < 3'd2);

    // Start is a pure function of the registered state, so it is glitch-free
    // and falls on the edge that samples Done high.
    assign Computation_Start = (state == ST_WAIT_DONE);
    assign Busy              = (state != ST_IDLE);
    assign State_Dbg         = state;

    // State register.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and combinational outputs.
    always_comb begin
        state_next        = state;
        cmd_take          = 1'b0;
        load_beat         = 1'b0;
        start_set         = 1'b0;
        kcyc_inc          = 1'b0;
        rd_issue          = 1'b0;
        Cmd_Ready         = 1'b0;
        In_Ready          = 1'b0;
        Bram_En           = 1'b0;
        Bram_Wen          = '0;
        Bram_Addr         = '0;
        Bram_Data_To_Bram = '0;
        Job_Done          = 1'b0;
        case (state)
            ST_IDLE: begin
                Cmd_Ready = ready_en;
                if (Cmd_Valid && ready_en) begin
                    cmd_take   = 1'b1;
                    state_next = (Cmd_Load_Len == '0) ? ST_ARM : ST_LOAD;
                end
            end
            ST_LOAD: begin
                In_Ready = 1'b1;
                if (In_Valid) begin
                    load_beat         = 1'b1;
                    Bram_En           = 1'b1;
                    Bram_Wen          = '1;
                    Bram_Addr         = load_addr;
                    Bram_Data_To_Bram = In_Data;
                    if (last_load) begin
                        state_next = ST_ARM;
                    end
                end
            end
            ST_ARM: begin
                // A Done left high by the previous job must clear first.
                if (!Computation_Done) begin
                    start_set  = 1'b1;
                    state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (Computation_Done) begin
                    state_next = ST_RELEASE;
                end else begin
                    kcyc_inc = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!Computation_Done) begin
                    state_next = (store_len == '0) ? ST_FINISH : ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                if (issue_ok) begin
                    rd_issue  = 1'b1;
                    Bram_En   = 1'b1;
                    Bram_Addr = store_addr;
                end
                if (out_pop && last_out) begin
                    state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                Job_Done   = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Command latch, word counters, read tracking and kernel cycle count.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            ready_en      <= 1'b0;
            load_base     <= '0;
            store_base    <= '0;
            load_len      <= '0;
            store_len     <= '0;
            idx           <= '0;
            out_cnt       <= '0;
            rd_pend       <= 1'b0;
            Kernel_Cycles <= '0;
        end else begin
            ready_en <= 1'b1;
            rd_pend  <= rd_issue;
            if (cmd_take) begin
                load_base  <= Cmd_Load_Base;
                store_base <= Cmd_Store_Base;
                load_len   <= Cmd_Load_Len;
                store_len  <= Cmd_Store_Len;
                idx        <= '0;
                out_cnt    <= '0;
            end
            if (load_beat) begin
                idx <= last_load ? '0 : idx + LEN_WIDTH'(1);
            end
            if (start_set) begin
                idx           <= '0;
                Kernel_Cycles <= '0;
            end
            if (kcyc_inc) begin
                Kernel_Cycles <= kcyc_step(Kernel_Cycles);
            end
            if (rd_issue) begin
                idx <= idx + LEN_WIDTH'(1);
            end
            if (out_pop) begin
                out_cnt <= out_cnt + LEN_WIDTH'(1);
            end
        end
    end

    // Result buffer between the BRAM read port and the Out stream.
    cgra_out_fifo #(
        .WIDTH (SYS_DWIDTH)
    ) u_out_fifo (
        .clk       (Clk),
        .rst_n     (Resetn),
        .push      (rd_pend),
        .push_data (Bram_Data_From_Bram),
        .out_ready (Out_Ready),
        .out_valid (Out_Valid),
        .out_data  (Out_Data),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_cgra_host_ctrl.sv
// Directed bench for cgra_host_ctrl with a behavioural BRAM and a scripted
// Start/Done responder.
module tb_cgra_host_ctrl;
  import cgra_host_pkg::*;

  logic        Clk;
  logic        Resetn;
  logic        Cmd_Valid;
  logic        Cmd_Ready;
  logic [31:0] Cmd_Load_Base;
  logic [31:0] Cmd_Store_Base;
  logic [15:0] Cmd_Load_Len;
  logic [15:0] Cmd_Store_Len;
  logic        In_Valid;
  logic        In_Ready;
  logic [31:0] In_Data;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [31:0] Out_Data;
  logic        Bram_En;
  logic [3:0]  Bram_Wen;
  logic [31:0] Bram_Addr;
  logic [31:0] Bram_Data_To_Bram;
  logic [31:0] Bram_Data_From_Bram;
  logic        Computation_Start;
  logic        Computation_Done;
  logic        Busy;
  logic        Job_Done;
  logic [31:0] Kernel_Cycles;
  host_state_t State_Dbg;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int en_cnt = 0;
  int jd_cnt = 0;
  bit [31:0] mem [1024];
  bit        wr_flag [1024];

  cgra_host_ctrl #(
    .SYS_DWIDTH (32),
    .BYTE_LEN   (4),
    .LEN_WIDTH  (16)
  ) dut (
    .Clk                 (Clk),
    .Resetn              (Resetn),
    .Cmd_Valid           (Cmd_Valid),
    .Cmd_Ready           (Cmd_Ready),
    .Cmd_Load_Base       (Cmd_Load_Base),
    .Cmd_Store_Base      (Cmd_Store_Base),
    .Cmd_Load_Len        (Cmd_Load_Len),
    .Cmd_Store_Len       (Cmd_Store_Len),
    .In_Valid            (In_Valid),
    .In_Ready            (In_Ready),
    .In_Data             (In_Data),
    .Out_Valid           (Out_Valid),
    .Out_Ready           (Out_Ready),
    .Out_Data            (Out_Data),
    .Bram_En             (Bram_En),
    .Bram_Wen            (Bram_Wen),
    .Bram_Addr           (Bram_Addr),
    .Bram_Data_To_Bram   (Bram_Data_To_Bram),
    .Bram_Data_From_Bram (Bram_Data_From_Bram),
    .Computation_Start   (Computation_Start),
    .Computation_Done    (Computation_Done),
    .Busy                (Busy),
    .Job_Done            (Job_Done),
    .Kernel_Cycles       (Kernel_Cycles),
    .State_Dbg           (State_Dbg)
  );

  // clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // BRAM model: words never written read back as 0xC0DE0000 | addr[15:0]
  always @(posedge Clk) begin
    if (Bram_En) begin
      en_cnt++;
      if (Bram_Wen != 4'h0) begin
        mem[Bram_Addr[11:2]] = Bram_Data_To_Bram;
        wr_flag[Bram_Addr[11:2]] = 1'b1;
        wa_q.push_back(Bram_Addr);
        wd_q.push_back(Bram_Data_To_Bram);
      end else begin
        Bram_Data_From_Bram <= wr_flag[Bram_Addr[11:2]] ? mem[Bram_Addr[11:2]]
                                                        : (32'hC0DE_0000 | {16'h0, Bram_Addr[15:0]});
      end
    end
    if (Job_Done) jd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic send_cmd(input logic [31:0] lb, input logic [15:0] ll,
                          input logic [31:0] sb, input logic [15:0] sl);
    int t = 0;
    while (!Cmd_Ready && t < 50) begin
      @(negedge Clk);
      t++;
    end
    check("cmd_ready", 32'(Cmd_Ready), 32'd1);
    Cmd_Valid      = 1'b1;
    Cmd_Load_Base  = lb;
    Cmd_Load_Len   = ll;
    Cmd_Store_Base = sb;
    Cmd_Store_Len  = sl;
    @(negedge Clk);
    Cmd_Valid = 1'b0;
  endtask

  task automatic load_words(input int n, input logic [31:0] first);
    for (int i = 0; i < n; i++) begin
      In_Valid = 1'b1;
      In_Data  = first + i;
      @(negedge Clk);
    end
    In_Valid = 1'b0;
    In_Data  = '0;
  endtask

  // Raise Done n cycles after Start is seen, then drop it once Start falls.
  task automatic handshake(input string tag, input int n);
    int t = 0;
    while (!Computation_Start && t < 100) begin
      @(negedge Clk);
      t++;
    end
    check({tag, "_start"}, 32'(Computation_Start), 32'd1);
    repeat (n) @(negedge Clk);
    check({tag, "_start_held"}, 32'(Computation_Start), 32'd1);
    Computation_Done = 1'b1;
    @(negedge Clk);
    check({tag, "_start_fall"}, 32'(Computation_Start), 32'd0);
    check({tag, "_state_release"}, 32'(State_Dbg), 32'(ST_RELEASE));
    check({tag, "_kcyc"}, Kernel_Cycles, n);
    Computation_Done = 1'b0;
  endtask

  task automatic unload(input string tag, input int n, input bit toggle);
    int  t = 0;
    int  cyc = 0;
    int  got = 0;
    bit  seen = 0;
    while (State_Dbg != ST_UNLOAD && t < 50) begin
      @(negedge Clk);
      t++;
    end
    check({tag, "_unload"}, 32'(State_Dbg), 32'(ST_UNLOAD));
    Out_Ready = 1'b1;
    while (got < n && cyc < 200) begin
      if (Out_Valid) begin
        if (!seen) begin
          check({tag, "_first_lat"}, cyc, 32'd2);
          seen = 1;
        end
        if (exp_q.size() == 0) begin
          check({tag, "_extra"}, 32'(Out_Valid), 32'd0);
        end else begin
          check({tag, "_data"}, Out_Data, exp_q[0]);
          if (Out_Ready) begin
            void'(exp_q.pop_front());
            got++;
          end
        end
      end
      @(negedge Clk);
      cyc++;
      if (toggle) Out_Ready = ~Out_Ready;
    end
    check({tag, "_count"}, got, n);
    Out_Ready = 1'b0;
  endtask

  task automatic wait_job_done(input string tag);
    int t = 0;
    while (!Job_Done && t < 100) begin
      @(negedge Clk);
      t++;
    end
    check({tag, "_job_done"}, 32'(Job_Done), 32'd1);
    @(negedge Clk);
    check({tag, "_job_done_pulse"}, 32'(Job_Done), 32'd0);
    check({tag, "_idle"}, 32'(Busy), 32'd0);
  endtask

  // stimulus
  initial begin
    int wb;
    int e0;
    int j0;
    logic [31:0] t6_addr [4];
    t6_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    Resetn = 1'b1;
    Cmd_Valid = 1'b0;
    Cmd_Load_Base = '0;
    Cmd_Store_Base = '0;
    Cmd_Load_Len = '0;
    Cmd_Store_Len = '0;
    In_Valid = 1'b0;
    In_Data = '0;
    Out_Ready = 1'b0;
    Computation_Done = 1'b0;
    #1 Resetn = 1'b0;

    // reset values
    repeat (2) @(negedge Clk);
    check("rst_cmd_ready", 32'(Cmd_Ready), 32'd0);
    check("rst_in_ready", 32'(In_Ready), 32'd0);
    check("rst_out_valid", 32'(Out_Valid), 32'd0);
    check("rst_out_data", Out_Data, 32'd0);
    check("rst_bram_en", 32'(Bram_En), 32'd0);
    check("rst_start", 32'(Computation_Start), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_job_done", 32'(Job_Done), 32'd0);
    check("rst_kcyc", Kernel_Cycles, 32'd0);
    Resetn = 1'b1;
    @(negedge Clk);
    check("post_rst_cmd_ready", 32'(Cmd_Ready), 32'd1);
    check("post_rst_state", 32'(State_Dbg), 32'(ST_IDLE));

    // t1: load 1..4 at 0x100, no store, Done 10 cycles after Start
    wb = wa_q.size();
    send_cmd(32'h100, 16'd4, 32'h0, 16'd0);
    check("t1_state_load", 32'(State_Dbg), 32'(ST_LOAD));
    check("t1_in_ready", 32'(In_Ready), 32'd1);
    check("t1_busy", 32'(Busy), 32'd1);
    load_words(4, 32'd1);
    check("t1_state_arm", 32'(State_Dbg), 32'(ST_ARM));
    check("t1_start_lo", 32'(Computation_Start), 32'd0);
    @(negedge Clk);
    check("t1_start_rise", 32'(Computation_Start), 32'd1);
    handshake("t1", 10);
    @(negedge Clk);
    check("t1_job_done", 32'(Job_Done), 32'd1);
    @(negedge Clk);
    check("t1_job_done_pulse", 32'(Job_Done), 32'd0);
    check("t1_idle", 32'(Busy), 32'd0);
    check("t1_kcyc_hold", Kernel_Cycles, 32'd10);
    check("t1_wr_count", wa_q.size() - wb, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t1_wr_addr", wa_q[wb + i], 32'h100 + 32'(4 * i));
      check("t1_wr_data", wd_q[wb + i], 32'(i + 1));
    end

    // t2: store 8 from preloaded 0x200 with Out_Ready toggling
    wb = wa_q.size();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'hC0DE_0200 + 32'(4 * i));
    send_cmd(32'h0, 16'd0, 32'h200, 16'd8);
    handshake("t2", 3);
    unload("t2", 8, 1'b1);
    wait_job_done("t2");
    check("t2_no_writes", wa_q.size() - wb, 32'd0);

    // t3: Done already high at ARM
    Computation_Done = 1'b1;
    e0 = en_cnt;
    send_cmd(32'h0, 16'd0, 32'h0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      check("t3_state_arm", 32'(State_Dbg), 32'(ST_ARM));
      check("t3_start_lo", 32'(Computation_Start), 32'd0);
      @(negedge Clk);
    end
    Computation_Done = 1'b0;
    @(negedge Clk);
    check("t3_start_rise", 32'(Computation_Start), 32'd1);
    handshake("t3", 2);
    wait_job_done("t3");
    check("t3_no_bram", en_cnt - e0, 32'd0);

    // t4: handshake-only job
    e0 = en_cnt;
    j0 = jd_cnt;
    send_cmd(32'h0, 16'd0, 32'h0, 16'd0);
    check("t4_state_arm", 32'(State_Dbg), 32'(ST_ARM));
    handshake("t4", 5);
    wait_job_done("t4");
    check("t4_no_bram", en_cnt - e0, 32'd0);
    check("t4_one_done", jd_cnt - j0, 32'd1);

    // t5: reset while waiting for Done
    send_cmd(32'h0, 16'd0, 32'h0, 16'd0);
    @(negedge Clk);
    check("t5_wait_state", 32'(State_Dbg), 32'(ST_WAIT_DONE));
    repeat (3) @(negedge Clk);
    j0 = jd_cnt;
    Resetn = 1'b0;
    #1;
    check("t5_start_drop", 32'(Computation_Start), 32'd0);
    check("t5_busy_drop", 32'(Busy), 32'd0);
    check("t5_cmd_ready_rst", 32'(Cmd_Ready), 32'd0);
    check("t5_kcyc_rst", Kernel_Cycles, 32'd0);
    @(negedge Clk);
    Resetn = 1'b1;
    repeat (3) @(negedge Clk);
    check("t5_no_job_done", jd_cnt - j0, 32'd0);
    check("t5_state_idle", 32'(State_Dbg), 32'(ST_IDLE));

    // t6: address wrap at 0xFFFFFFF8, load 4 then read them back
    wb = wa_q.size();
    send_cmd(32'hFFFF_FFF8, 16'd4, 32'hFFFF_FFF8, 16'd4);
    load_words(4, 32'hA0);
    handshake("t6", 7);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + 32'(i));
    unload("t6", 4, 1'b0);
    wait_job_done("t6");
    check("t6_wr_count", wa_q.size() - wb, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t6_wr_addr", wa_q[wb + i], t6_addr[i]);
    end

    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cgra_host_ctrl.md
# cgra_host_ctrl

Host-side job controller for the 2x2 SCGRA: the initiator end of the `Computation_Start`/`Computation_Done` handshake and the host-side master of the shared data BRAM. For each job it:
- streams input words into the BRAM;
- raises `Computation_Start` and waits for the array to finish;
- completes the four-phase handshake;
- streams result words back out with backpressure.

It sits between the host bus adapter and the CGRA's shared I/O buffer. The CGRA's BRAM interface is the responder on the other side.

## Interface
Parameters:
- SYS_DWIDTH, 32, data and BRAM address width
- BYTE_LEN, 4, byte lanes per word; address stride per word
- LEN_WIDTH, 16, word-count width

Ports:
- Clk  in  1  single clock
- Resetn  in  1  reset; asynchronous, active-low
- Cmd_Valid / Cmd_Ready  in/out  1  job command handshake
- Cmd_Load_Base, Cmd_Store_Base  in  SYS_DWIDTH  byte base addresses, word-aligned
- Cmd_Load_Len, Cmd_Store_Len  in  LEN_WIDTH  word counts
- In_Valid / In_Ready  in/out  1  input stream handshake; In_Data  in  SYS_DWIDTH
- Out_Valid / Out_Ready  out/in  1  result stream handshake; Out_Data  out  SYS_DWIDTH
- Bram_En  out  1;  Bram_Wen  out  BYTE_LEN;  Bram_Addr  out  SYS_DWIDTH;  Bram_Data_To_Bram  out  SYS_DWIDTH;  Bram_Data_From_Bram  in  SYS_DWIDTH
- Computation_Start  out  1;  Computation_Done  in  1
- Busy  out  1  high in any state other than IDLE
- Job_Done  out  1  one-cycle pulse when a job completes
- Kernel_Cycles  out  32  cycles from Start rise to Done rise, saturating

## Operation
- States: IDLE, LOAD, ARM, WAIT_DONE, RELEASE, UNLOAD, FINISH.
- IDLE:
  - Cmd_Ready=1.
  - On Cmd_Valid, latch the command and go to LOAD; go to ARM instead if Load_Len=0.
- LOAD:
  - In_Ready=1.
  - Each In_Valid beat: Bram_En=1, Bram_Wen=all ones, Addr=Load_Base+4*idx, Data=In_Data.
  - After the final beat, go to ARM.
- ARM:
  - Waits while Computation_Done=1 (stale done from a previous job).
  - Once Done=0: assert Computation_Start, clear Kernel_Cycles, go to WAIT_DONE.
- WAIT_DONE:
  - Start held high; Kernel_Cycles increments each cycle and saturates at 0xFFFFFFFF.
  - On Done=1: deassert Start, go to RELEASE.
- RELEASE:
  - Waits for Done=0.
  - Then go to UNLOAD, or to FINISH if Store_Len=0.
- UNLOAD:
  - Reads issue at Store_Base+4*idx with Bram_En=1, Wen=0.
  - Read data returns one cycle later and is pushed into the 2-entry output FIFO.
  - A read issues only when FIFO occupancy plus reads in flight is less than 2.
  - Go to FINISH after the last word has been accepted on the Out stream.
- FINISH: Job_Done=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^SYS_DWIDTH; idx is LEN_WIDTH bits.
- A reset in any state aborts the job:
  - FIFO cleared, Start dropped.
  - No partial Job_Done.

## Timing
- Reset values:
  - State IDLE.
  - Cmd_Ready=0 while Resetn is low, 1 in IDLE after reset.
  - All other outputs 0: In_Ready, Out_Valid, Out_Data, Bram_*, Computation_Start, Busy, Job_Done, Kernel_Cycles.
- Write latency: BRAM write occurs in the same cycle as the In beat; full rate, 1 word per cycle.
- Read latency: first Out_Valid two cycles after UNLOAD entry; sustained 1 word per cycle while Out_Ready=1.
- Out_Data is stable while Out_Valid=1 and Out_Ready=0.
- Handshake order is strictly Start↑ → Done↑ → Start↓ → Done↓:
  - Start falls the cycle after Done is sampled high.
  - Done held high forever leaves the block in RELEASE; no timeout.
- Command to Start rise: Load_Len+1 cycles minimum (ARM takes one cycle).
- Kernel_Cycles holds its value from Done↑ until the next ARM.

## Structure
- Shared package `cgra_host_pkg`: state enum, WORD_STRIDE=BYTE_LEN, KCYC_MAX constant.
- One sub-module: `cgra_out_fifo`, a 2-entry synchronous FIFO with valid/ready output and a count output for read-issue gating.

## Test plan
- Load_Len=4 (data 1..4, base 0x100), Store_Len=0; Done rises 10 cycles after Start:
  - writes at 0x100/104/108/10C;
  - Kernel_Cycles=10;
  - Start falls 1 cycle after Done↑;
  - Job_Done 1 cycle after Done↓.
- Store_Len=8 with base 0x200 and BRAM preloaded, Out_Ready toggling 1/0 each cycle:
  - 8 words out in address order, none lost or duplicated;
  - Out_Data stable during stalls.
- Done already high at ARM: Start stays 0 until Done drops, then rises the next cycle.
- Load_Len=0, Store_Len=0: the job performs only the handshake; Bram_En never asserted.
- Resetn pulsed low in WAIT_DONE: Start=0 and Busy=0 immediately; the next command runs normally.
- Base 0xFFFFFFF8 with Load_Len=4: addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
